// File: rtl/tt_um_adder_test_ss_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tt_um_adder_test_ss_pkg
// Purpose  : Shared constants for the adder bring-up tile.
//            WIDTH            - operand/result width, fixed by the TT pinout
//            UIO_OE_ALL_INPUT - output-enable value leaving every bidir pin
//                               as an input
// Revision : 1.0 - initial release
// ============================================================================
package tt_um_adder_test_ss_pkg;
  localparam int          WIDTH            = 8;
  localparam logic [7:0]  UIO_OE_ALL_INPUT = 8'h00;
endpackage
`default_nettype wire

// File: rtl/tt_um_adder_test_ss_full_adder.sv
`default_nettype none
// ============================================================================
// Module   : full_adder
// Purpose  : Single-bit full adder cell, one link of the ripple-carry chain.
// Ports    : a, b   - operand bits
//            cin    - carry from the next-lower bit
//            sum    - a ^ b ^ cin
//            cout   - carry to the next-higher bit
// Revision : 1.0 - initial release
// ============================================================================
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule
`default_nettype wire

// File: rtl/tt_um_adder_test_ss.sv
`default_nettype none
// ============================================================================
// Module   : tt_um_adder_test_ss
// Purpose  : Tiny Tapeout user tile - 8-bit unsigned adder with a registered
//            result. Sum wraps modulo 256 (carry-out discarded).
// Ports    : clk     - system clock, rising edge
//            rst_n   - asynchronous reset, active HIGH (harness name kept)
//            ena     - tile enable; result register captures only while 1
//            ui_in   - operand A
//            uio_in  - operand B (bidir pins used as inputs only)
//            uo_out  - registered sum, no combinational path from inputs
//            uio_out - tied to 0
//            uio_oe  - tied to 0 (all bidir pins are inputs)
// Revision : 1.0 - initial release
// ============================================================================
module tt_um_adder_test_ss
  import tt_um_adder_test_ss_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] carry;     // carry[i] is the carry into bit i
  logic             carry_out_unused;
  logic [WIDTH-1:0] result;

  assign carry[0] = 1'b0;

  // Ripple chain: each cell hands its carry to the next bit; the carry out
  // of the top bit is dropped so the sum wraps modulo 2**WIDTH.
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
      if (i < WIDTH - 1) begin : g_mid
        full_adder u_fa (
          .a    (ui_in[i]),
          .b    (uio_in[i]),
          .cin  (carry[i]),
          .sum  (sum[i]),
          .cout (carry[i+1])
        );
      end else begin : g_msb
        full_adder u_fa (
          .a    (ui_in[i]),
          .b    (uio_in[i]),
          .cin  (carry[i]),
          .sum  (sum[i]),
          .cout (carry_out_unused)
        );
      end
    end
  endgenerate

  // Reset wins over enable; with ena low the previous sum is held.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      result <= '0;
    end else if (ena) begin
      result <= sum;
    end
  end

  assign uo_out  = result;
  assign uio_out = 8'h00;
  assign uio_oe  = UIO_OE_ALL_INPUT;

endmodule
`default_nettype wire

// File: tb/tb_tt_um_adder_test_ss.sv
`default_nettype none
// ============================================================================
// Module   : tb_tt_um_adder_test_ss
// Purpose  : Self-checking bench for the registered 8-bit adder tile.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tt_um_adder_test_ss;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int vectors;
  int errors;

  tt_um_adder_test_ss dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h55;
    uio_in = 8'h22;
    repeat (3) step();
    vectors++;
    if (uo_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_uo_out got=%h exp=00", uo_out);
    end
    vectors++;
    if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
      errors++;
      $display("FAIL reset_tieoffs got uio_out=%h uio_oe=%h exp=00/00", uio_out, uio_oe);
    end
    // Release, capture 0x55+0x22, then reset between edges.
    @(negedge clk);
    rst_n = 1'b0;
    step();
    vectors++;
    if (uo_out !== 8'h77) begin
      errors++;
      $display("FAIL reset_release_capture got=%h exp=77", uo_out);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    vectors++;
    if (uo_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_async got=%h exp=00", uo_out);
    end
  endtask

  task automatic test_basic();
    @(negedge clk);
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'd20;
    uio_in = 8'd22;
    #1;
    vectors++;
    if (uo_out !== 8'd0) begin
      errors++;
      $display("FAIL basic_before_edge got=%0d exp=0", uo_out);
    end
    step();
    vectors++;
    if (uo_out !== 8'd42) begin
      errors++;
      $display("FAIL basic_add got=%0d exp=42", uo_out);
    end
  endtask

  task automatic test_boundary();
    logic [7:0] a_tab [5] = '{8'd255, 8'd255, 8'd128, 8'd0, 8'd255};
    logic [7:0] b_tab [5] = '{8'd1,   8'd255, 8'd128, 8'd0, 8'd0};
    logic [7:0] e_tab [5] = '{8'd0,   8'd254, 8'd0,   8'd0, 8'd255};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ena    = 1'b1;
      ui_in  = a_tab[i];
      uio_in = b_tab[i];
      step();
      vectors++;
      if (uo_out !== e_tab[i]) begin
        errors++;
        $display("FAIL boundary_%0d %0d+%0d got=%0d exp=%0d",
                 i, a_tab[i], b_tab[i], uo_out, e_tab[i]);
      end
    end
  endtask

  task automatic test_enable_hold();
    @(negedge clk);
    ena    = 1'b1;
    ui_in  = 8'd3;
    uio_in = 8'd4;
    step();
    vectors++;
    if (uo_out !== 8'd7) begin
      errors++;
      $display("FAIL hold_capture got=%0d exp=7", uo_out);
    end
    @(negedge clk);
    ena    = 1'b0;
    ui_in  = 8'd100;
    uio_in = 8'd100;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (uo_out !== 8'd7) begin
        errors++;
        $display("FAIL hold_cycle_%0d got=%0d exp=7", i, uo_out);
      end
    end
    @(negedge clk);
    ena = 1'b1;
    step();
    vectors++;
    if (uo_out !== 8'd200) begin
      errors++;
      $display("FAIL hold_resume got=%0d exp=200", uo_out);
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    vectors++;
    if (uo_out !== 8'd0) begin
      errors++;
      $display("FAIL midstream_reset got=%0d exp=0", uo_out);
    end
    @(negedge clk);
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'd1;
    uio_in = 8'd1;
    step();
    vectors++;
    if (uo_out !== 8'd2) begin
      errors++;
      $display("FAIL midstream_recover got=%0d exp=2", uo_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] full;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      a      = 8'($urandom_range(0, 255));
      b      = 8'($urandom_range(0, 255));
      ena    = 1'b1;
      ui_in  = a;
      uio_in = b;
      full   = {1'b0, a} + {1'b0, b};
      step();
      vectors++;
      if (uo_out !== full[7:0] || uio_out !== 8'h00 || uio_oe !== 8'h00) begin
        errors++;
        $display("FAIL random_%0d %0d+%0d got=%0d exp=%0d uio_out=%h uio_oe=%h",
                 n, a, b, uo_out, full[7:0], uio_out, uio_oe);
      end
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst_n   = 1'b1;
    ena     = 1'b0;
    ui_in   = 8'h00;
    uio_in  = 8'h00;
    test_reset();
    test_basic();
    test_boundary();
    test_enable_hold();
    test_reset_midstream();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tt_um_adder_test_ss.md
Name: tt_um_adder_test_ss

Overview:
- Tiny Tapeout user tile: 8-bit unsigned adder with a registered result.
- Operand A arrives on the dedicated inputs; operand B arrives on the bidirectional pins, which are used as inputs only.
- The sum is registered on the dedicated outputs.
- Top-level tile sitting directly under the TT harness; serves as an adder bring-up/test vehicle.

Parameters:
- WIDTH, 8, operand and result width. Fixed by the TT pinout; do not override.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  reset. Asynchronous, active-high: asserted when 1. Name kept from the harness.
- ena  input  1  tile enable; result register updates only while 1.
- ui_in  input  8  operand A, unsigned.
- uio_in  input  8  operand B, unsigned.
- uo_out  output  8  registered sum (A+B) mod 256.
- uio_out  output  8  tied to 8'h00.
- uio_oe  output  8  tied to 8'h00; all bidirectional pins are inputs.

Behaviour:
- Combinational sum S = ui_in + uio_in, 8 bits. Carry-out of bit 7 is discarded, so results wrap modulo 256.
- Adder structure: ripple-carry chain of WIDTH full-adder cells. Carry-in to bit 0 is 0.
- Result register R, 8 bits, drives uo_out directly.
- Reset: while rst_n=1, R=8'h00 immediately, independent of clk. This holds even mid-operation; the prior value is lost.
- Release of reset takes effect asynchronously. The first capture is the first rising clk edge with rst_n=0 and ena=1.
- Capture: on rising clk, if rst_n=0 and ena=1, then R <= S.
- Hold: on rising clk, if ena=0, R keeps its value and input changes are ignored.
- Latency: exactly 1 clock from stable inputs to uo_out. Inputs must be stable at the capturing edge.
- uo_out has no combinational path from ui_in or uio_in.
- Priority: reset > ena > capture. If rst_n=1 and ena=1 together, R=0.
- uio_out and uio_oe are constant 0 at all times, including during reset.
- No X propagation allowed: every output is defined from reset onward.
- Boundaries:
  - 0+0=0.
  - 255+0=255.
  - 255+1=0 (wrap).
  - 255+255=254.
  - 128+128=0.

Decomposition:
- Shared package: constant WIDTH=8 and constant UIO_OE_ALL_INPUT=8'h00. No typedefs needed.
- One natural sub-module: full_adder (a, b, cin -> sum, cout), instantiated WIDTH times via generate to form the ripple chain.
- Top level holds the result register, enable gating and output tie-offs.

Test Plan:
- Reset: rst_n=1 with ui_in=8'h55, uio_in=8'h22 and clk running -> uo_out=0, uio_out=0, uio_oe=0. Assert rst_n mid-cycle with no clk edge -> uo_out=0 immediately.
- Basic add: release reset, ena=1, ui_in=20, uio_in=22 -> after one rising edge uo_out=42. Before that edge uo_out=0.
- Wrap/boundary, one per cycle with ena=1; each result appears on the following edge:
  - 255+1 -> 0
  - 255+255 -> 254
  - 128+128 -> 0
  - 0+0 -> 0
  - 255+0 -> 255
- Enable hold: capture 3+4 -> uo_out=7; set ena=0, ui_in=100, uio_in=100, run 5 clocks -> uo_out stays 7. Set ena=1 -> next edge uo_out=200.
- Reset mid-stream: uo_out=200; assert rst_n between edges -> uo_out=0 at once. Deassert, ui_in=1, uio_in=1, ena=1 -> next edge uo_out=2.
- Randomized: 1000 cycles of random A/B with ena=1 -> uo_out at cycle n+1 equals (A_n + B_n) & 8'hFF. uio_oe=0 and uio_out=0 throughout.
